commit_trace_buf: RTL and testbench

//  Parametrised multi-channel capture buffer for architectural commit records.

---
 rtl/commit_trace_buf_pkg.sv | 29 ++
 rtl/commit_trace_buf_if.sv | 20 ++
 rtl/commit_trace_buf_compactor.sv | 28 ++
 rtl/commit_trace_buf.sv | 154 +++++++++++++++
 tb/tb_commit_trace_buf.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_trace_buf_pkg.sv
// Package for the commit trace buffer.
// Holds the capture-mode and trigger-phase enums, the drop counter width and
// the mode_i decode helper. 3 on mode_i is an alias for STREAM.
package commit_trace_buf_pkg;

  typedef enum logic [1:0] {
    TM_STREAM  = 2'd0,
    TM_RING    = 2'd1,
    TM_TRIGGER = 2'd2
  } trace_mode_e;

  // Trigger phase: ARMED behaves as a ring, POST counts down, DONE freezes capture.
  typedef enum logic [1:0] {
    TS_ARMED = 2'd0,
    TS_POST  = 2'd1,
    TS_DONE  = 2'd2
  } trig_state_e;

  localparam int TRACE_DROP_W = 16;

  function automatic trace_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return TM_RING;
      2'd2:    return TM_TRIGGER;
      default: return TM_STREAM;
    endcase
  endfunction

endpackage

// File: rtl/commit_trace_buf_if.sv
// Record capture / drain bus for the commit trace buffer.
//  in_valid  : per-channel record valid (lower index = older record)
//  in_rec    : per-channel records
//  out_valid : buffer non-empty
//  out_rec   : oldest record (first-word fall-through)
//  out_ready : consumer accepts out_rec
// master = core/consumer side, slave = the buffer.
interface commit_trace_buf_if #(
  parameter int NCH   = 2,
  parameter int REC_W = 48
);
  logic [NCH-1:0]            in_valid;
  logic [NCH-1:0][REC_W-1:0] in_rec;
  logic                      out_valid;
  logic [REC_W-1:0]          out_rec;
  logic                      out_ready;

  modport master (output in_valid, in_rec, out_ready, input out_valid, out_rec);
  modport slave  (input in_valid, in_rec, out_ready, output out_valid, out_rec);
endinterface

// File: rtl/commit_trace_buf_compactor.sv
// trace_compactor: combinational prefix-sum over the active channel mask.
//  active_i : channels presenting a record this cycle
//  sel_o    : sel_o[s] = channel index feeding write slot s (slots packed, channel order)
//  k_o      : number of active channels
module trace_compactor #(
  parameter int NCH = 2,
  parameter int SW  = 1,
  parameter int KW  = 2
) (
  input  logic [NCH-1:0]         active_i,
  output logic [NCH-1:0][SW-1:0] sel_o,
  output logic [KW-1:0]          k_o
);

  always_comb begin
    int n;
    n     = 0;
    sel_o = '0;
    for (int c = 0; c < NCH; c++) begin
      if (active_i[c]) begin
        sel_o[n] = SW'(c);
        n        = n + 1;
      end
    end
    k_o = KW'(n);
  end

endmodule

// File: rtl/commit_trace_buf.sv
// commit_trace_buf: multi-channel capture buffer for commit records.
// Accepts up to NCH records per cycle into a DEPTH-entry circular buffer,
// drained over a valid/ready stream. Modes: STREAM (drop new when full),
// RING (overwrite oldest), TRIGGER (ring until trig_i, then capture
// post_cnt_i more records and freeze).
//  clk, rst      : clock, synchronous active-high reset
//  clear_i       : synchronous flush, latches mode_i
//  mode_i        : capture mode (0/3 STREAM, 1 RING, 2 TRIGGER)
//  enable_i      : capture enable
//  trig_i        : trigger pulse (TRIGGER mode)
//  post_cnt_i    : records captured after the trigger (sampled on trigger)
//  bus           : record capture and drain stream (slave side)
//  count_o       : occupied entries
//  drop_cnt_o    : dropped/overwritten records, saturating
//  triggered_o   : trigger seen since last clear
//  done_o        : post-trigger capture complete
module commit_trace_buf
  import commit_trace_buf_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 16,
  parameter int REC_W = 48,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic [1:0]                mode_i,
  input  logic                      enable_i,
  input  logic                      trig_i,
  input  logic [CNT_W-1:0]          post_cnt_i,
  commit_trace_buf_if.slave         bus,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [TRACE_DROP_W-1:0]   drop_cnt_o,
  output logic                      triggered_o,
  output logic                      done_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int KW = $clog2(NCH + 1);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DROP_MAX = (1 << TRACE_DROP_W) - 1;

  logic [DEPTH-1:0][REC_W-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count_q;
  logic [TRACE_DROP_W-1:0]     drop_q, drop_d;
  logic [CNT_W-1:0]            rem_q;
  trace_mode_e                 mode_q;
  trig_state_e                 st_q, st_d;

  logic [NCH-1:0]              active;
  logic [NCH-1:0][SW-1:0]      sel;
  logic [KW-1:0]               k;
  logic                        out_valid, pop, flush;
  logic                        trig_now, post_phase;
  int                          acc_i, ovf_i, fill_i, rem_i, pop_i, budget_i;

  assign flush     = rst | clear_i;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & bus.out_ready;

  assign bus.out_valid = out_valid;
  assign bus.out_rec   = mem[rd_ptr];
  assign count_o       = count_q;
  assign drop_cnt_o    = drop_q;
  assign triggered_o   = (st_q != TS_ARMED);
  assign done_o        = (st_q == TS_DONE);

  assign active = bus.in_valid & {NCH{enable_i & (st_q != TS_DONE)}};

  trace_compactor #(.NCH(NCH), .SW(SW), .KW(KW)) u_cmp (
    .active_i (active),
    .sel_o    (sel),
    .k_o      (k)
  );

  // Accept/overflow arithmetic. Written records are always the first acc_i
  // compacted slots, so lower channels win whenever capture is limited.
  always_comb begin
    int k_i, cnt_i, drop_inc, drop_sum;
    k_i        = int'(k);
    cnt_i      = int'(count_q);
    pop_i      = pop ? 1 : 0;
    trig_now   = (mode_q == TM_TRIGGER) && (st_q == TS_ARMED) && trig_i && enable_i;
    post_phase = trig_now || (st_q == TS_POST);
    // Records in the trigger cycle already count against post_cnt_i.
    budget_i   = trig_now ? int'(post_cnt_i) : int'(rem_q);
    acc_i      = k_i;
    ovf_i      = 0;
    drop_inc   = 0;
    if (mode_q == TM_STREAM) begin
      // Free space ignores a same-cycle pop.
      if (acc_i > DEPTH - cnt_i) acc_i = DEPTH - cnt_i;
      drop_inc = k_i - acc_i;
      fill_i   = cnt_i - pop_i + acc_i;
    end else begin
      // Excess beyond the post-trigger budget is silently ignored, not dropped.
      if (post_phase && acc_i > budget_i) acc_i = budget_i;
      fill_i = cnt_i - pop_i + acc_i;
      if (fill_i > DEPTH) begin
        ovf_i  = fill_i - DEPTH;
        fill_i = DEPTH;
      end
      drop_inc = ovf_i;
    end
    rem_i    = budget_i - acc_i;
    drop_sum = int'(drop_q) + drop_inc;
    drop_d   = (drop_sum > DROP_MAX) ? TRACE_DROP_W'(DROP_MAX) : TRACE_DROP_W'(drop_sum);
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      TS_ARMED: if (trig_now) st_d = (rem_i == 0) ? TS_DONE : TS_POST;
      TS_POST:  if (rem_i == 0) st_d = TS_DONE;
      default:  st_d = st_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) st_q <= TS_ARMED;
    else       st_q <= st_d;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      rem_q   <= '0;
      mode_q  <= decode_mode(mode_i);
    end else begin
      wr_ptr  <= wr_ptr + PW'(acc_i);
      // Overwritten entries are skipped by moving the read side forward.
      rd_ptr  <= rd_ptr + PW'(pop_i + ovf_i);
      count_q <= CW'(fill_i);
      drop_q  <= drop_d;
      if (post_phase) rem_q <= CNT_W'(rem_i);
    end
  end

  // Storage has no reset; pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int s = 0; s < NCH; s++) begin
        if (s < acc_i) mem[wr_ptr + PW'(s)] <= bus.in_rec[sel[s]];
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buf.sv
module tb_commit_trace_buf;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_i;
  logic [1:0]  mode_i;
  logic        enable_i;
  logic        trig_i;
  logic [7:0]  post_cnt_i;
  logic [4:0]  count_o;
  logic [15:0] drop_cnt_o;
  logic        triggered_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  commit_trace_buf_if #(.NCH(2), .REC_W(48)) bus ();

  commit_trace_buf #(.NCH(2), .DEPTH(DEPTH), .REC_W(48), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear_i),
    .mode_i      (mode_i),
    .enable_i    (enable_i),
    .trig_i      (trig_i),
    .post_cnt_i  (post_cnt_i),
    .bus         (bus),
    .count_o     (count_o),
    .drop_cnt_o  (drop_cnt_o),
    .triggered_o (triggered_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [47:0] mq[$];
  int m_drop, m_rem, m_mode;
  bit m_trig, m_done;

  function automatic int sat_inc(int v);
    return (v < 65535) ? v + 1 : 65535;
  endfunction

  function automatic void model_reset(logic [1:0] md);
    mq.delete();
    m_drop = 0; m_rem = 0; m_trig = 0; m_done = 0;
    m_mode = (md == 2'd1) ? 1 : (md == 2'd2) ? 2 : 0;
  endfunction

  function automatic void model_step(bit clr, logic [1:0] md, bit en, bit trg, logic [7:0] pc,
                                     logic [1:0] v, logic [47:0] r0, logic [47:0] r1, bit rdy);
    logic [47:0] act[$];
    bit popped;
    int room;
    if (clr) begin
      model_reset(md);
      return;
    end
    if (en && !m_done) begin
      if (v[0]) act.push_back(r0);
      if (v[1]) act.push_back(r1);
    end
    popped = rdy && (mq.size() > 0);
    if (m_mode == 0) begin
      room = DEPTH - mq.size();
      while (act.size() > room) begin
        void'(act.pop_back());
        m_drop = sat_inc(m_drop);
      end
    end else if (m_mode == 2) begin
      if (!m_trig && trg && en) begin
        m_trig = 1;
        m_rem  = pc;
      end
      if (m_trig) begin
        while (act.size() > m_rem) void'(act.pop_back());
        m_rem -= act.size();
        if (m_rem == 0) m_done = 1;
      end
    end
    if (popped) void'(mq.pop_front());
    foreach (act[i]) begin
      mq.push_back(act[i]);
      if (mq.size() > DEPTH) begin
        void'(mq.pop_front());
        m_drop = sat_inc(m_drop);
      end
    end
  endfunction

  // ---------------- stimulus ----------------
  logic [1:0] cur_md = 2'd0;

  task automatic step(bit clr, logic [1:0] md, bit en, bit trg, logic [7:0] pc,
                      logic [1:0] v, logic [47:0] r0, logic [47:0] r1, bit rdy);
    clear_i      = clr;
    mode_i       = md;
    enable_i     = en;
    trig_i       = trg;
    post_cnt_i   = pc;
    bus.in_valid = v;
    bus.in_rec[0] = r0;
    bus.in_rec[1] = r1;
    bus.out_ready = rdy;
    model_step(clr, md, en, trg, pc, v, r0, r1, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(logic [1:0] md);
    cur_md = md;
    step(1, md, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic push1(logic [47:0] r, bit rdy);
    step(0, cur_md, 1, 0, 0, 2'b01, r, 0, rdy);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    clear_i = 0; mode_i = 0; enable_i = 0; trig_i = 0; post_cnt_i = 0;
    bus.in_valid = 0; bus.in_rec = '0; bus.out_ready = 0;
    model_reset(2'd0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
    checks++; if (triggered_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got trig=%b done=%b want 0 0", triggered_o, done_o); end
    rst = 0;
  endtask

  task automatic test_stream_basic();
    do_clear(2'd0);
    for (int i = 1; i <= 5; i++) push1(48'hA0_0000 + 48'(i), 0);
    checks++; if (count_o !== 5'd5) begin errors++; $display("FAIL stream_count: got %0d want 5", count_o); end
    checks++; if (bus.out_rec !== 48'hA0_0001) begin errors++; $display("FAIL stream_head: got %h want a00001", bus.out_rec); end
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL stream_drop: got %0d want 0", drop_cnt_o); end
  endtask

  task automatic test_stream_full();
    logic [47:0] last;
    int budget;
    for (int i = 6; i <= 16; i++) push1(48'hA0_0000 + 48'(i), 0);
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL full_count: got %0d want 16", count_o); end
    // Full with pop: pop is not credited, both dropped.
    step(0, cur_md, 1, 0, 0, 2'b11, 48'hB1, 48'hB2, 1);
    checks++; if (count_o !== 5'd15) begin errors++; $display("FAIL full_pop_count: got %0d want 15", count_o); end
    checks++; if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL full_pop_drop: got %0d want 2", drop_cnt_o); end
    checks++; if (bus.out_rec !== 48'hA0_0002) begin errors++; $display("FAIL full_pop_head: got %h want a00002", bus.out_rec); end
    // One slot left: ch0 kept, ch1 dropped.
    step(0, cur_md, 1, 0, 0, 2'b11, 48'hC0, 48'hC1, 0);
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL one_free_count: got %0d want 16", count_o); end
    checks++; if (drop_cnt_o !== 16'd3) begin errors++; $display("FAIL one_free_drop: got %0d want 3", drop_cnt_o); end
    last = '0;
    budget = 40;
    while (bus.out_valid === 1'b1 && budget > 0) begin
      checks++; if (mq.size() > 0 && bus.out_rec !== mq[0]) begin
        errors++; $display("FAIL stream_drain: got %h want %h", bus.out_rec, mq[0]); end
      last = bus.out_rec;
      step(0, cur_md, 0, 0, 0, 2'b00, 0, 0, 1);
      budget--;
    end
    checks++; if (budget == 0) begin errors++; $display("FAIL stream_drain_timeout: got no empty want empty"); end
    checks++; if (last !== 48'hC0) begin errors++; $display("FAIL stream_last: got %h want c0", last); end
  endtask

  task automatic test_ring();
    do_clear(2'd1);
    for (int i = 0; i < 20; i++) push1(48'(i), 0);
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL ring_count: got %0d want 16", count_o); end
    checks++; if (drop_cnt_o !== 16'd4) begin errors++; $display("FAIL ring_drop: got %0d want 4", drop_cnt_o); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_rec !== 48'(i + 4)) begin
        errors++; $display("FAIL ring_drain[%0d]: got v=%b %0d want v=1 %0d", i, bus.out_valid, bus.out_rec, i + 4); end
      step(0, cur_md, 0, 0, 0, 2'b00, 0, 0, 1);
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ring_empty: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_trigger();
    do_clear(2'd2);
    for (int i = 0; i < 30; i++) begin
      step(0, cur_md, 1, (i == 10), 8'd3, 2'b01, 48'(i), 0, 0);
      if (i == 10) begin
        checks++; if (triggered_o !== 1'b1) begin errors++; $display("FAIL trig_flag: got %b want 1", triggered_o); end
      end
      if (i == 11) begin
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL trig_early_done: got %b want 0", done_o); end
      end
      if (i == 12) begin
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL trig_done: got %b want 1", done_o); end
      end
    end
    checks++; if (count_o !== 5'd13) begin errors++; $display("FAIL trig_count: got %0d want 13", count_o); end
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL trig_drop: got %0d want 0", drop_cnt_o); end
    for (int i = 0; i < 13; i++) begin
      checks++; if (bus.out_rec !== 48'(i)) begin
        errors++; $display("FAIL trig_drain[%0d]: got %0d want %0d", i, bus.out_rec, i); end
      step(0, cur_md, 1, 0, 8'd3, 2'b11, 48'hDEAD, 48'hBEEF, 1);
    end
    checks++; if (count_o !== 5'd0 || done_o !== 1'b1 || drop_cnt_o !== 16'd0) begin
      errors++; $display("FAIL trig_frozen: got cnt=%0d done=%b drop=%0d want 0 1 0", count_o, done_o, drop_cnt_o); end
  endtask

  task automatic test_trigger_zero();
    do_clear(2'd2);
    for (int i = 0; i < 3; i++) push1(48'h300 + 48'(i), 0);
    step(0, cur_md, 1, 1, 8'd0, 2'b01, 48'h77, 0, 0);
    checks++; if (triggered_o !== 1'b1 || done_o !== 1'b1) begin
      errors++; $display("FAIL post0_flags: got trig=%b done=%b want 1 1", triggered_o, done_o); end
    checks++; if (count_o !== 5'd3) begin errors++; $display("FAIL post0_count: got %0d want 3", count_o); end
  endtask

  task automatic test_clear();
    do_clear(2'd0);
    for (int i = 0; i < 6; i++) push1(48'h500 + 48'(i), 0);
    for (int i = 0; i < 2; i++) step(0, cur_md, 0, 0, 0, 2'b00, 0, 0, 1);
    cur_md = 2'd1;
    step(1, 2'd1, 1, 0, 0, 2'b11, 48'h5A, 48'h5B, 1);
    checks++; if (count_o !== 5'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL clear_empty: got cnt=%0d v=%b want 0 0", count_o, bus.out_valid); end
    checks++; if (drop_cnt_o !== 16'd0 || triggered_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL clear_flags: got drop=%0d trig=%b done=%b want 0 0 0", drop_cnt_o, triggered_o, done_o); end
    for (int i = 0; i < 17; i++) push1(48'd100 + 48'(i), 0);
    checks++; if (drop_cnt_o !== 16'd1 || bus.out_rec !== 48'd101) begin
      errors++; $display("FAIL clear_new_mode: got drop=%0d head=%0d want 1 101", drop_cnt_o, bus.out_rec); end
  endtask

  task automatic test_random();
    int rdy_bias;
    rdy_bias = 3;
    do_clear(2'd0);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 119) == 0) begin
        do_clear(2'($urandom_range(0, 3)));
        rdy_bias = $urandom_range(1, 6);
      end else begin
        step(0, cur_md, ($urandom_range(0, 7) != 0), ($urandom_range(0, 19) == 0),
             8'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
             {16'h0, 32'($urandom)}, {16'h1, 32'($urandom)}, ($urandom_range(0, rdy_bias) == 0));
      end
      checks++; if (count_o !== 5'(mq.size()) || bus.out_valid !== (mq.size() > 0)) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d/%b want %0d", n, count_o, bus.out_valid, mq.size()); end
      checks++; if (mq.size() > 0 && bus.out_rec !== mq[0]) begin
        errors++; $display("FAIL rand_head[%0d]: got %h want %h", n, bus.out_rec, mq[0]); end
      checks++; if (drop_cnt_o !== 16'(m_drop)) begin
        errors++; $display("FAIL rand_drop[%0d]: got %0d want %0d", n, drop_cnt_o, m_drop); end
      checks++; if (triggered_o !== m_trig || done_o !== m_done) begin
        errors++; $display("FAIL rand_flags[%0d]: got %b%b want %b%b", n, triggered_o, done_o, m_trig, m_done); end
    end
  endtask

  task automatic test_drop_sat();
    do_clear(2'd0);
    for (int i = 0; i < 8; i++) step(0, cur_md, 1, 0, 0, 2'b11, 48'(2 * i), 48'(2 * i + 1), 0);
    for (int i = 0; i < 32768; i++) step(0, cur_md, 1, 0, 0, 2'b11, 48'hE0, 48'hE1, 0);
    checks++; if (drop_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL drop_sat: got %h want ffff", drop_cnt_o); end
    step(0, cur_md, 1, 0, 0, 2'b11, 48'hE0, 48'hE1, 0);
    checks++; if (drop_cnt_o !== 16'hFFFF || count_o !== 5'd16) begin
      errors++; $display("FAIL drop_hold: got %h cnt=%0d want ffff 16", drop_cnt_o, count_o); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream_basic();
    test_stream_full();
    test_ring();
    test_trigger();
    test_trigger_zero();
    test_clear();
    test_random();
    test_drop_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
